// File: rtl/dlx_alu_issue_pkg.sv
// Shared DLX definitions for the ALU issue block: opcode and ALU function
// encodings, instruction field positions and the decoded stage-1 record.
package dlx_alu_issue_pkg;

    localparam int unsigned XLEN    = 32;

    // Instruction field bit positions
    localparam int unsigned OPC_HI  = 31;
    localparam int unsigned OPC_LO  = 26;
    localparam int unsigned RS1_HI  = 25;
    localparam int unsigned RS1_LO  = 21;
    localparam int unsigned RS2_HI  = 20;
    localparam int unsigned RS2_LO  = 16;
    localparam int unsigned RDR_HI  = 15;
    localparam int unsigned RDR_LO  = 11;
    localparam int unsigned RDI_HI  = 20;
    localparam int unsigned RDI_LO  = 16;
    localparam int unsigned FUNC_HI = 5;
    localparam int unsigned FUNC_LO = 0;
    localparam int unsigned IMM_HI  = 15;
    localparam int unsigned IMM_LO  = 0;

    // DLX major opcodes handled by this block
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h08,
        OP_SUBI  = 6'h0a,
        OP_ANDI  = 6'h0c,
        OP_ORI   = 6'h0d,
        OP_XORI  = 6'h0e,
        OP_LHI   = 6'h0f,
        OP_SLLI  = 6'h14,
        OP_SRLI  = 6'h16,
        OP_SRAI  = 6'h17,
        OP_SEQI  = 6'h18,
        OP_SNEI  = 6'h19,
        OP_SLTI  = 6'h1a,
        OP_SGTI  = 6'h1b,
        OP_SLEI  = 6'h1c,
        OP_SGEI  = 6'h1d
    } dlx_op_e;

    // ALU function codes (identical to the DLX R-type func field)
    typedef enum logic [5:0] {
        ALU_SLL  = 6'h04,
        ALU_SRL  = 6'h06,
        ALU_SRA  = 6'h07,
        ALU_ADD  = 6'h20,
        ALU_ADDU = 6'h21,
        ALU_SUB  = 6'h22,
        ALU_AND  = 6'h24,
        ALU_OR   = 6'h25,
        ALU_XOR  = 6'h26,
        ALU_SEQ  = 6'h28,
        ALU_SNE  = 6'h29,
        ALU_SLT  = 6'h2a,
        ALU_SGT  = 6'h2b,
        ALU_SLE  = 6'h2c,
        ALU_SGE  = 6'h2d
    } alu_func_e;

    // Decoded instruction held in stage 1
    typedef struct packed {
        alu_func_e         func;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [4:0]        rd;
        logic              we;
        logic              err;
    } dec_stage_t;

endpackage

// File: rtl/dlx_alu_issue_alu.sv
// 32-bit DLX ALU: shifts, add/sub, logic ops and signed set-if compares.
// Purely combinational; unknown function codes yield zero.
module alu_32
    import dlx_alu_issue_pkg::*;
(
    input  alu_func_e         func_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   result_o
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a_i;
    assign b_s = b_i;

    // Function select; shift amount comes from the low five bits of B
    always_comb begin
        result_o = '0;
        case (func_i)
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $unsigned(a_s >>> b_i[4:0]);
            ALU_ADD,
            ALU_ADDU: result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SEQ:  result_o = {{(XLEN-1){1'b0}}, a_i == b_i};
            ALU_SNE:  result_o = {{(XLEN-1){1'b0}}, a_i != b_i};
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, a_s <  b_s};
            ALU_SGT:  result_o = {{(XLEN-1){1'b0}}, a_s >  b_s};
            ALU_SLE:  result_o = {{(XLEN-1){1'b0}}, a_s <= b_s};
            ALU_SGE:  result_o = {{(XLEN-1){1'b0}}, a_s >= b_s};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/dlx_alu_issue.sv
// DLX ALU issue block: decodes an instruction into ALU func/operands
// (stage 1), executes it through alu_32 and registers the result (stage 2).
// Valid/ready on both sides, full throughput, no bubbles.
// Optional macro DLX_ALU_ISSUE_ILLEGAL_EN: flag illegal instructions with
// out_err instead of executing them as ADD rs1_val+rs2_val.
module dlx_alu_issue
    import dlx_alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_err
);

    dec_stage_t        dec;
    dec_stage_t        s1_q, s1_d;
    logic              s1_valid_q, s1_valid_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_we_q, out_we_d;
    logic              out_err_q, out_err_d;
    logic [XLEN-1:0]   alu_result;
    logic              s2_load;
    logic              accept;

    logic [5:0]        opcode;
    logic [5:0]        rfunc;
    logic [15:0]       imm;
    logic              legal;
    logic              unused_rs1_idx;

    assign opcode = in_instr[OPC_HI:OPC_LO];
    assign rfunc  = in_instr[FUNC_HI:FUNC_LO];
    assign imm    = in_instr[IMM_HI:IMM_LO];

    // Source register indices are resolved upstream; operand values arrive directly
    assign unused_rs1_idx = ^in_instr[RS1_HI:RS1_LO];

    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    // Instruction decode into ALU func, operands and writeback control
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        dec.func  = ALU_ADD;
        dec.a     = in_rs1_val;
        dec.b     = in_rs2_val;
        dec.rd    = in_instr[RDI_HI:RDI_LO];
        if (opcode == OP_RTYPE) begin
            dec.rd = in_instr[RDR_HI:RDR_LO];
            case (rfunc)
                ALU_SLL, ALU_SRL, ALU_SRA, ALU_ADD, ALU_ADDU, ALU_SUB,
                ALU_AND, ALU_OR, ALU_XOR, ALU_SEQ, ALU_SNE, ALU_SLT,
                ALU_SGT, ALU_SLE, ALU_SGE: dec.func = alu_func_e'(rfunc);
                default:                   legal    = 1'b0;
            endcase
        end else begin
            case (opcode)
                OP_ADDI: begin dec.func = ALU_ADD; dec.b = {{16{imm[15]}}, imm}; end
                OP_SUBI: begin dec.func = ALU_SUB; dec.b = {{16{imm[15]}}, imm}; end
                OP_ANDI: begin dec.func = ALU_AND; dec.b = {16'h0000, imm}; end
                OP_ORI:  begin dec.func = ALU_OR;  dec.b = {16'h0000, imm}; end
                OP_XORI: begin dec.func = ALU_XOR; dec.b = {16'h0000, imm}; end
                OP_SLLI: begin dec.func = ALU_SLL; dec.b = {16'h0000, imm}; end
                OP_SRLI: begin dec.func = ALU_SRL; dec.b = {16'h0000, imm}; end
                OP_SRAI: begin dec.func = ALU_SRA; dec.b = {16'h0000, imm}; end
                OP_LHI: begin
                    dec.func = ALU_OR;
                    dec.a    = '0;
                    dec.b    = {imm, 16'h0000};
                end
                // Set-if opcodes 0x18..0x1d map one-to-one onto funcs 0x28..0x2d
                OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: begin
                    dec.func = alu_func_e'(opcode + 6'h10);
                    dec.b    = {{16{imm[15]}}, imm};
                end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
`ifdef DLX_ALU_ISSUE_ILLEGAL_EN
            dec.err  = 1'b1;
`else
            dec.err  = 1'b0;
`endif
            dec.func = ALU_ADD;
            dec.a    = in_rs1_val;
            dec.b    = in_rs2_val;
        end
        dec.we = (dec.rd != 5'd0) && !dec.err;
    end

    // Next-state for both pipeline stages
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_d         = s1_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_we_d     = out_we_q;
        out_err_d    = out_err_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = dec;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = s1_q.err ? '0 : alu_result;
                out_rd_d     = s1_q.rd;
                out_we_d     = s1_q.we;
                out_err_d    = s1_q.err;
            end
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight work
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_we_q     <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_we_q     <= out_we_d;
            out_err_q    <= out_err_d;
        end
    end

    alu_32 u_alu (
        .func_i   (s1_q.func),
        .a_i      (s1_q.a),
        .b_i      (s1_q.b),
        .result_o (alu_result)
    );

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_we     = out_we_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_dlx_alu_issue.sv
// Directed testbench for dlx_alu_issue with hand-computed expected values.
// Honours DLX_ALU_ISSUE_ILLEGAL_EN for the illegal-instruction vectors.
module tb_dlx_alu_issue;
    import dlx_alu_issue_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    dlx_alu_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .out_err    (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd, input logic [15:0] imm);
        return {op, 5'd1, rd, imm};
    endfunction

    // Issue one instruction into an empty pipeline and check latency and result
    task automatic run_single(input string tag, input logic [31:0] instr,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_res, input logic [4:0] exp_rd,
                              input logic exp_we, input logic exp_err);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_instr   = instr;
        in_rs1_val = a;
        in_rs2_val = b;
        #2;
        check_eq({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_lat"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_res"}, out_result, exp_res);
        check_eq({tag, "_rd"},  {27'd0, out_rd}, {27'd0, exp_rd});
        check_eq({tag, "_we"},  {31'd0, out_we}, {31'd0, exp_we});
        check_eq({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        @(posedge clk); #1;
    endtask

    logic [31:0] exp_res_q [8];
    logic [4:0]  exp_rd_q  [8];

    initial begin
        int  sent;
        int  recvd;
        bit  saw_stall;
        bit  acc;

        rst        = 1'b1;
        in_valid   = 1'b1;
        in_instr   = mk_i(OP_ADDI, 5'd9, 16'h0001);
        in_rs1_val = 32'h0000_0100;
        in_rs2_val = '0;
        out_ready  = 1'b1;

        // Reset state; in_valid offered during reset must be ignored
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_result", out_result, 32'd0);
        check_eq("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check_eq("rst_out_we", {31'd0, out_we}, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("rst_no_accept", {31'd0, out_valid}, 32'd0);
        end

        // Directed single-instruction vectors
        run_single("addi",  mk_i(OP_ADDI, 5'd3, 16'hFFFD), 32'h0000_0005, 32'h0, 32'h0000_0002, 5'd3, 1'b1, 1'b0);
        run_single("ori",   mk_i(OP_ORI,  5'd4, 16'h8001), 32'hF000_0000, 32'h0, 32'hF000_8001, 5'd4, 1'b1, 1'b0);
        run_single("lhi",   mk_i(OP_LHI,  5'd5, 16'h1234), 32'hDEAD_0000, 32'h0, 32'h1234_0000, 5'd5, 1'b1, 1'b0);
        run_single("slt",   mk_r(5'd6, 6'h2a), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'd6, 1'b1, 1'b0);
        run_single("sge",   mk_r(5'd6, 6'h2d), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd6, 1'b1, 1'b0);
        run_single("add_r0", mk_r(5'd0, 6'h20), 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 5'd0, 1'b0, 1'b0);
        run_single("subi",  mk_i(OP_SUBI, 5'd10, 16'hFFFF), 32'h0000_000A, 32'h0, 32'h0000_000B, 5'd10, 1'b1, 1'b0);
        run_single("andi",  mk_i(OP_ANDI, 5'd11, 16'h8000), 32'hFFFF_FFFF, 32'h0, 32'h0000_8000, 5'd11, 1'b1, 1'b0);
        run_single("xori",  mk_i(OP_XORI, 5'd12, 16'h8000), 32'h1234_5678, 32'h0, 32'h1234_D678, 5'd12, 1'b1, 1'b0);
        run_single("srai",  mk_i(OP_SRAI, 5'd13, 16'h0004), 32'h8000_0000, 32'h0, 32'hF800_0000, 5'd13, 1'b1, 1'b0);
        run_single("srli",  mk_i(OP_SRLI, 5'd14, 16'h0004), 32'h8000_0000, 32'h0, 32'h0800_0000, 5'd14, 1'b1, 1'b0);
        run_single("slli",  mk_i(OP_SLLI, 5'd15, 16'h001F), 32'h0000_0001, 32'h0, 32'h8000_0000, 5'd15, 1'b1, 1'b0);
        run_single("seqi",  mk_i(OP_SEQI, 5'd16, 16'hFFFF), 32'hFFFF_FFFF, 32'h0, 32'h0000_0001, 5'd16, 1'b1, 1'b0);
        run_single("slti",  mk_i(OP_SLTI, 5'd17, 16'hFFFF), 32'hFFFF_FFFE, 32'h0, 32'h0000_0001, 5'd17, 1'b1, 1'b0);
        run_single("sub",   mk_r(5'd18, 6'h22), 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 5'd18, 1'b1, 1'b0);
        run_single("xor",   mk_r(5'd19, 6'h26), 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 5'd19, 1'b1, 1'b0);
`ifdef DLX_ALU_ISSUE_ILLEGAL_EN
        run_single("ill_op",   {6'h3f, 5'd1, 5'd7, 16'h0000}, 32'h0000_0010, 32'h0000_0022, 32'h0000_0000, 5'd7, 1'b0, 1'b1);
        run_single("ill_func", mk_r(5'd8, 6'h23), 32'h0000_0005, 32'h0000_0001, 32'h0000_0000, 5'd8, 1'b0, 1'b1);
`else
        run_single("ill_op",   {6'h3f, 5'd1, 5'd7, 16'h0000}, 32'h0000_0010, 32'h0000_0022, 32'h0000_0032, 5'd7, 1'b1, 1'b0);
        run_single("ill_func", mk_r(5'd8, 6'h23), 32'h0000_0005, 32'h0000_0001, 32'h0000_0006, 5'd8, 1'b1, 1'b0);
`endif

        // Back-to-back stream of 8 ADDIs with out_ready low in cycles 3..5
        for (int k = 0; k < 8; k++) begin
            exp_res_q[k] = 32'h12 * k;
            exp_rd_q[k]  = 5'(k + 1);
        end
        sent      = 0;
        recvd     = 0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                in_valid   = 1'b1;
                in_instr   = mk_i(OP_ADDI, 5'(sent + 1), 16'(sent));
                in_rs1_val = 32'h11 * sent;
                in_rs2_val = '0;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                check_eq("stream_res", out_result, exp_res_q[recvd]);
                check_eq("stream_rd", {27'd0, out_rd}, {27'd0, exp_rd_q[recvd]});
                if (out_ready) recvd++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check_eq("stream_count", recvd, 32'd8);
        check_eq("stream_stall_seen", {31'd0, saw_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("stream_no_dup", {31'd0, out_valid}, 32'd0);
        end

        // Reset with both stages full
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_instr   = mk_i(OP_ADDI, 5'd9, 16'h0001);
        in_rs1_val = 32'h0000_0041;
        @(posedge clk); #1;
        in_instr   = mk_i(OP_ADDI, 5'd10, 16'h0002);
        @(posedge clk); #1;
        #1;
        check_eq("full_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("full_out_valid", {31'd0, out_valid}, 32'd1);
        check_eq("full_out_result", out_result, 32'h0000_0042);
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_out_result", out_result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
